// File: rtl/bcast_fifo.sv
// rtl/bcast_fifo.sv - single-writer, multi-reader broadcast FIFO
//
// Purpose:
//   One DEPTH-entry storage array is shared by N_CH downstream channels. Every
//   accepted upstream word is delivered once, in order, to each channel that
//   is enabled when the word is pushed. Each channel has its own read pointer;
//   the write side stalls while any enabled channel is full.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-low reset (clears all pointers)
//   up_valid    upstream word offered
//   up_ready    upstream word can be accepted
//   up_data     upstream word
//   ch_en       per-channel subscribe enable
//   down_valid  per-channel word available
//   down_ready  per-channel consumer accepts
//   down_data   channel i word on [i*D_WIDTH +: D_WIDTH] (show-ahead)
//   level       channel i occupancy on [i*(A_WIDTH+1) +: A_WIDTH+1]

module bcast_fifo #(
  parameter int D_WIDTH = 6,
  parameter int A_WIDTH = 2,
  parameter int N_CH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          up_valid,
  output logic                          up_ready,
  input  logic [D_WIDTH-1:0]            up_data,
  input  logic [N_CH-1:0]               ch_en,
  output logic [N_CH-1:0]               down_valid,
  input  logic [N_CH-1:0]               down_ready,
  output logic [N_CH*D_WIDTH-1:0]       down_data,
  output logic [N_CH*(A_WIDTH+1)-1:0]   level
);

  localparam int PW    = A_WIDTH + 1;
  localparam int DEPTH = 1 << A_WIDTH;

  // Occupancy value meaning "full" in pointer-difference arithmetic.
  localparam logic [PW-1:0] FULL_CNT = {1'b1, {A_WIDTH{1'b0}}};

  logic [D_WIDTH-1:0] mem_q    [DEPTH];
  logic [PW-1:0]      wr_ptr_q;
  logic [PW-1:0]      wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q [N_CH];
  logic [PW-1:0]      rd_ptr_d [N_CH];
  logic [PW-1:0]      cnt      [N_CH];
  logic               push;
  logic [N_CH-1:0]    pop;

  // Per-channel occupancy from the pointer distance; the extra pointer bit
  // distinguishes full from empty.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt[i] = wr_ptr_q - rd_ptr_q[i];
    end
  end

  // Backpressure looks only at registered pointers and ch_en, so there is
  // no combinational path from down_ready to up_ready.
  always_comb begin
    up_ready = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_en[i] && (cnt[i] == FULL_CNT)) begin
        up_ready = 1'b0;
      end
    end
  end

  assign push = up_valid & up_ready;

  always_comb begin
    down_valid = '0;
    down_data  = '0;
    level      = '0;
    for (int i = 0; i < N_CH; i++) begin
      down_valid[i]               = ch_en[i] && (cnt[i] != '0);
      down_data[i*D_WIDTH +: D_WIDTH] = mem_q[rd_ptr_q[i][A_WIDTH-1:0]];
      level[i*PW +: PW]           = cnt[i];
    end
  end

  assign pop = down_valid & down_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{A_WIDTH{1'b0}}, push};
    for (int i = 0; i < N_CH; i++) begin
      // A disabled channel tracks the post-edge write pointer so it stays
      // empty and, on enable, starts with the word pushed on that same edge.
      if (ch_en[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + {{A_WIDTH{1'b0}}, pop[i]};
      end else begin
        rd_ptr_d[i] = wr_ptr_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        rd_ptr_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      for (int i = 0; i < N_CH; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
    end
  end

  // Storage is not reset; emptiness is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[A_WIDTH-1:0]] <= up_data;
    end
  end

endmodule
